// File: rtl/dff_async_load_ctrl.sv
// rtl/dff_async_load_ctrl.sv - sequences async PRE/CLR loads into a preset/clear flip-flop bank
// Holds the bank cleared in reset, then pulses PRE/CLR for PULSE_CYC and gates its clock through recovery.
module dff_async_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 3,
  parameter int RECOV_CYC = 2
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] reg_pre,
  output logic [WIDTH-1:0] reg_clr,
  output logic             reg_clk_en,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ASSERT, S_RECOVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pre_q, pre_d;
  logic [WIDTH-1:0]   clr_q, clr_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_W'(RECOV_CYC - 1);
      pre_q   <= '0;
      clr_q   <= '1;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_ASSERT;
          cnt_d   = CNT_W'(PULSE_CYC - 1);
        end
      end
      S_ASSERT: begin
        if (cnt_zero) begin
          state_d = S_RECOVER;
          cnt_d   = CNT_W'(RECOV_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_zero) state_d = S_IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  // Next values of the registered outputs; PRE/CLR hold themselves, so load_data is only sampled on acceptance.
  always_comb begin
    pre_d  = '0;
    clr_d  = '0;
    en_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_INIT: en_d = cnt_zero;
      S_IDLE: begin
        if (start) begin
          pre_d  = load_data;
          clr_d  = ~load_data;
          busy_d = 1'b1;
        end else begin
          en_d = 1'b1;
        end
      end
      S_ASSERT: begin
        busy_d = 1'b1;
        if (!cnt_zero) begin
          pre_d = pre_q;
          clr_d = clr_q;
        end
      end
      S_RECOVER: begin
        if (cnt_zero) begin
          en_d   = 1'b1;
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign reg_pre    = pre_q;
  assign reg_clr    = clr_q;
  assign reg_clk_en = en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dff_async_load_ctrl.sv
// tb/tb_dff_async_load_ctrl.sv - self-checking bench for dff_async_load_ctrl
module tb_dff_async_load_ctrl;

  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic       start = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] reg_pre, reg_clr;
  logic       reg_clk_en, busy, done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] pre;
    logic [7:0] clr;
    logic       en;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic       start;
    logic [7:0] data;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  dff_async_load_ctrl #(.WIDTH(8), .PULSE_CYC(3), .RECOV_CYC(2)) dut (
    .clk(clk), .CLR(CLR), .start(start), .load_data(load_data),
    .reg_pre(reg_pre), .reg_clr(reg_clr), .reg_clk_en(reg_clk_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".pre"},  {24'h0, reg_pre}, {24'h0, e.pre});
    chk({tag, ".clr"},  {24'h0, reg_clr}, {24'h0, e.clr});
    chk({tag, ".en"},   {31'h0, reg_clk_en}, {31'h0, e.en});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, e.busy});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, e.done});
  endtask

  function automatic vec_t v(input logic s, input logic [7:0] d, input logic [7:0] p,
                             input logic [7:0] c, input logic en, input logic b, input logic dn);
    vec_t r;
    r.start = s; r.data = d;
    r.exp.pre = p; r.exp.clr = c; r.exp.en = en; r.exp.busy = b; r.exp.done = dn;
    return r;
  endfunction

  function automatic exp_t e_of(input logic [7:0] p, input logic [7:0] c,
                                input logic en, input logic b, input logic dn);
    exp_t r;
    r.pre = p; r.clr = c; r.en = en; r.busy = b; r.done = dn;
    return r;
  endfunction

  // Invariants sampled on the falling edge, away from state changes
  always @(negedge clk) begin
    if (!CLR) begin
      chk("inv.overlap", {24'h0, reg_pre & reg_clr}, 32'h0);
      if ((reg_pre | reg_clr) != 8'h00) chk("inv.clk_en_gated", {31'h0, reg_clk_en}, 32'h0);
    end
  end

  initial begin
    exp_t e;

    // INIT recovery, then a plain load, with a stray start during ASSERT
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(v(1, 8'hA5, 8'hA5, 8'h5A, 0, 1, 0));
    vecs.push_back(v(1, 8'h3C, 8'hA5, 8'h5A, 0, 1, 0));
    vecs.push_back(v(0, 8'h3C, 8'hA5, 8'h5A, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    // All-zero then all-one words
    vecs.push_back(v(1, 8'h00, 8'h00, 8'hFF, 0, 1, 0));
    vecs.push_back(v(0, 8'h55, 8'h00, 8'hFF, 0, 1, 0));
    vecs.push_back(v(0, 8'h55, 8'h00, 8'hFF, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(v(1, 8'hFF, 8'hFF, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'hFF, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'hFF, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    // Back-to-back with start held: second load accepted on the done cycle
    vecs.push_back(v(1, 8'h0F, 8'h0F, 8'hF0, 0, 1, 0));
    vecs.push_back(v(1, 8'hF0, 8'h0F, 8'hF0, 0, 1, 0));
    vecs.push_back(v(1, 8'hF0, 8'h0F, 8'hF0, 0, 1, 0));
    vecs.push_back(v(1, 8'hF0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(1, 8'hF0, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(1, 8'hF0, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(v(1, 8'hF0, 8'hF0, 8'h0F, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'hF0, 8'h0F, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'hF0, 8'h0F, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(v(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));

    // Reset held for three cycles
    CLR = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("reset%0d", i), e_of(8'h00, 8'hFF, 0, 0, 0));
    end
    CLR = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      load_data = vecs[i].data;
      sb.push_back(vecs[i].exp);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        chk("sb.empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk_out($sformatf("vec%0d", i), e);
      end
    end
    chk("sb.drained", sb.size(), 32'h0);

    // Mid-load reset: abort during the second ASSERT cycle, without a clock edge
    start = 1'b1; load_data = 8'h81;
    @(posedge clk); #1;
    chk_out("mid.accept", e_of(8'h81, 8'h7E, 0, 1, 0));
    start = 1'b0;
    @(posedge clk); #2;
    chk_out("mid.assert2", e_of(8'h81, 8'h7E, 0, 1, 0));
    CLR = 1'b1;
    #1;
    chk_out("mid.async", e_of(8'h00, 8'hFF, 0, 0, 0));
    @(posedge clk); #1;
    chk_out("mid.held", e_of(8'h00, 8'hFF, 0, 0, 0));
    CLR = 1'b0;
    @(posedge clk); #1;
    chk_out("mid.init1", e_of(8'h00, 8'h00, 0, 0, 0));
    @(posedge clk); #1;
    chk_out("mid.init2", e_of(8'h00, 8'h00, 1, 0, 0));
    @(posedge clk); #1;
    chk_out("mid.idle", e_of(8'h00, 8'h00, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
